// File: rtl/lm32_dp_fifo_if.sv
// lm32_dp_fifo_if: producer/consumer bundle for the lm32_dp_fifo controller.
// The slave modport is the FIFO itself, the master modport is the user side.
// Optional macro: CFG_FIFO_LEVEL_EN adds the level_o occupancy signal.
interface lm32_dp_fifo_if #(
    parameter int data_width = 8,
    parameter int addr_width = 4
);
    logic                  we_i;
    logic [data_width-1:0] wdata_i;
    logic                  full_o;
    logic                  afull_o;
    logic                  re_i;
    logic [data_width-1:0] rdata_o;
    logic                  empty_o;
`ifdef CFG_FIFO_LEVEL_EN
    logic [addr_width:0]   level_o;
`endif

    modport master (
        output we_i, wdata_i, re_i,
        input  full_o, afull_o, rdata_o, empty_o
`ifdef CFG_FIFO_LEVEL_EN
        , input level_o
`endif
    );

    modport slave (
        input  we_i, wdata_i, re_i,
        output full_o, afull_o, rdata_o, empty_o
`ifdef CFG_FIFO_LEVEL_EN
        , output level_o
`endif
    );
endinterface

// File: rtl/lm32_dp_fifo.sv
// lm32_dp_fifo: first-word-fall-through FIFO controller around a dual-port RAM.
// Optional macro: CFG_FIFO_LEVEL_EN exposes the occupancy register as level_o.
// The read port registers its address (next read pointer) and reads the array
// asynchronously, so a word written into the head slot is visible next cycle.
module lm32_dp_fifo #(
    parameter int data_width  = 8,
    parameter int addr_width  = 4,
    parameter int afull_level = 12
) (
    input  logic               clk_i,
    input  logic               rst_i,
    lm32_dp_fifo_if.slave      bus
);
    localparam int DEPTH = 1 << addr_width;
    localparam logic [addr_width:0] LVL_FULL  = (addr_width+1)'(DEPTH);
    localparam logic [addr_width:0] LVL_AFULL = (addr_width+1)'(afull_level);

    logic [data_width-1:0] mem [DEPTH];

    // rptr_q doubles as the RAM's registered read address
    logic [addr_width-1:0] wptr_q, wptr_d;
    logic [addr_width-1:0] rptr_q, rptr_d;
    logic [addr_width:0]   level_q, level_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  afull_q, afull_d;
    logic                  we_acc, re_acc;

    // Accept push/pop, advance pointers and occupancy, derive next-state flags
    always_comb begin
        re_acc  = bus.re_i & ~empty_q;
        we_acc  = bus.we_i & (~full_q | re_acc);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (we_acc) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (re_acc) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({we_acc, re_acc})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_FULL);
        afull_d = (level_d >= LVL_AFULL);
    end

    // Pointer, level and flag registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            afull_q <= afull_d;
        end
    end

    // RAM write port; contents are never cleared and a push during reset is lost
    always_ff @(posedge clk_i) begin
        if (we_acc && rst_i) begin
            mem[wptr_q] <= bus.wdata_i;
        end
    end

    assign bus.rdata_o = empty_q ? '0 : mem[rptr_q];
    assign bus.empty_o = empty_q;
    assign bus.full_o  = full_q;
    assign bus.afull_o = afull_q;
`ifdef CFG_FIFO_LEVEL_EN
    assign bus.level_o = level_q;
`endif
endmodule

// File: doc/lm32_dp_fifo.md
# lm32_dp_fifo

Synchronous first-word-fall-through FIFO built around the team's dual-port RAM: this block is the pointer/flag controller that drives the RAM's write port from a producer and its read port on behalf of a consumer. One clock domain. Used as the buffering stage between LM32 bus-side producers (e.g. a UART RX path or DMA engine) and slower consumers.

## Interface

Parameters:
- data_width, 8, word width in bits.
- addr_width, 4, pointer width; depth = 2**addr_width entries.
- afull_level, 12, afull_o asserts when level >= afull_level; legal range 1..depth.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset; synchronous and active-low (asserted when 0, sampled on clk_i rising edge).
- we_i  in  1  push request.
- wdata_i  in  data_width  push data, sampled with we_i.
- full_o  out  1  level == depth.
- afull_o  out  1  level >= afull_level.
- re_i  in  1  pop request; acknowledges the word on rdata_o.
- rdata_o  out  data_width  head-of-queue word; forced to 0 while empty_o=1.
- empty_o  out  1  level == 0.
- level_o  out  addr_width+1  current occupancy (present only with CFG_FIFO_LEVEL_EN).

## Operation

- State: wptr, rptr (addr_width bits, wrap modulo depth), level (addr_width+1 bits, 0..depth).
- Storage: dual-port RAM, depth x data_width; write port = (we_acc, wptr, wdata_i); read address = rptr_next, registered inside the RAM, so rdata_o reflects mem[rptr] combinationally each cycle.
- Accepted push: we_acc = we_i & (~full_o | re_acc). Writes mem[wptr], wptr += 1.
- Accepted pop: re_acc = re_i & ~empty_o. rptr += 1.
- level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Push while full with no pop: dropped, no state change. Push while full with pop: both accepted, level stays depth.
- Pop while empty: ignored even if we_i=1 in the same cycle; the pushed word is accepted and becomes head next cycle.
- Pointer wrap: depth-1 -> 0 with no bubble.
- Read-during-write to the head address (level 0 -> 1, or wrap at level depth-1): rdata_o must show the newly written word in the cycle after the push; RAM read path is write-first by construction (registered address, asynchronous array read).
- Flags are registered, derived from next-state level.

## Timing

- Reset (rst_i=0 at edge): wptr=rptr=0, level=0; following cycle empty_o=1, full_o=0, afull_o=0, rdata_o=0, level_o=0. RAM contents not cleared. Reset wins over simultaneous we_i/re_i; a word pushed in the reset cycle is lost.
- Push-to-visible latency: push accepted at edge N into empty FIFO -> empty_o=0 and rdata_o=word from cycle N+1.
- Pop: re_i sampled at edge N -> next word (or empty_o=1, rdata_o=0) from cycle N+1.
- Sustained throughput: one push and one pop per cycle at any level.
- full_o/afull_o update in the cycle after the edge that changes level; no combinational path from we_i/re_i to any output.

## Configuration

- CFG_FIFO_LEVEL_EN defined: level_o port present, driven from the level register (reset 0).
- Not defined: level_o port absent; level register still exists internally for flags. Flag and data behaviour identical in both builds.

## Test plan

- Reset then idle: rst_i=0 for 2 cycles -> empty_o=1, full_o=0, afull_o=0, rdata_o=0, level_o=0.
- Single word: push 0xA5 at edge N -> cycle N+1 empty_o=0, rdata_o=0xA5, level_o=1; pop -> empty_o=1, rdata_o=0.
- Fill/overflow (addr_width=4): push 0x00..0x0F -> afull_o asserts after 12th push, full_o after 16th; 17th push 0xFF dropped; drain reads 0x00..0x0F in order.
- Full with simultaneous push/pop: at level 16, we_i=re_i=1 with 0x55 -> level stays 16, head advances, 0x55 read last after wrap.
- Empty with simultaneous push/pop: we_i=re_i=1, wdata 0x3C -> pop ignored, next cycle rdata_o=0x3C, level_o=1.
- Reset mid-stream: level 7, rst_i=0 with we_i=1 -> next cycle empty_o=1, level_o=0; subsequent push 0x11 reads back 0x11.
